jedro_1_wb_arbiter: RTL and testbench



---
 rtl/jedro_1_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_jedro_1_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_wb_arbiter.sv
// rtl/jedro_1_wb_arbiter.sv - N-source writeback arbiter with per-source FIFOs driving one register-file write port
module jedro_1_wb_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int FIFO_DEPTH     = 2,
    parameter int ARB_MODE       = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               flush_i,
    input  logic [NUM_SRC-1:0]                 src_valid_i,
    output logic [NUM_SRC-1:0]                 src_ready_o,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_addr_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data_i,
    output logic                               rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]          rf_addr_o,
    output logic [DATA_WIDTH-1:0]              rf_data_o,
    input  logic [REG_ADDR_WIDTH-1:0]          query_addr_i,
    output logic                               query_hit_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int RW    = REG_ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [RW-1:0]    r_fifo_addr [NUM_SRC][FIFO_DEPTH];
    logic [DW-1:0]    r_fifo_data [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr      [NUM_SRC];
    logic [PTR_W-1:0] r_rptr      [NUM_SRC];
    logic [CNT_W-1:0] r_count     [NUM_SRC];
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_we;
    logic [RW-1:0]    r_addr;
    logic [DW-1:0]    r_data;

    logic [NUM_SRC-1:0] w_accept;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [RW-1:0]      w_req_addr [NUM_SRC];
    logic [DW-1:0]      w_req_data [NUM_SRC];
    logic               w_any_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_off;
    logic               w_hit;

    // A non-empty FIFO presents its head; an empty one presents the incoming entry (bypass).
    always_comb begin
        src_ready_o = '0;
        w_accept    = '0;
        w_req       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ready_o[k] = (r_count[k] != FULL_CNT) && !flush_i && rstn_i;
            w_accept[k]    = src_valid_i[k] && src_ready_o[k] && (src_addr_i[k*RW +: RW] != '0);
            w_req[k]       = ((r_count[k] != '0) || w_accept[k]) && !flush_i;
            if (r_count[k] != '0) begin
                w_req_addr[k] = r_fifo_addr[k][r_rptr[k]];
                w_req_data[k] = r_fifo_data[k][r_rptr[k]];
            end else begin
                w_req_addr[k] = src_addr_i[k*RW +: RW];
                w_req_data[k] = src_data_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_any_grant = 1'b1;
                    w_grant_idx = IDX_W'(i);
                end
            end
        end else begin
            // Scan backwards so the nearest requester after rr_ptr is written last.
            for (int i = NUM_SRC; i >= 1; i--) begin
                w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_SRC);
                if (w_req[w_cand]) begin
                    w_any_grant = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        w_pop   = '0;
        w_push  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_grant[k] = w_any_grant && (w_grant_idx == IDX_W'(k));
            w_pop[k]   = w_grant[k] && (r_count[k] != '0);
            w_push[k]  = w_accept[k] && !(w_grant[k] && (r_count[k] == '0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_count[k] <= '0;
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
            end
            r_rr_ptr <= LAST_IDX;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else if (flush_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_count[k] <= '0;
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
            end
            r_rr_ptr <= LAST_IDX;
            r_we     <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (w_push[k]) begin
                    r_fifo_addr[k][r_wptr[k]] <= src_addr_i[k*RW +: RW];
                    r_fifo_data[k][r_wptr[k]] <= src_data_i[k*DW +: DW];
                    r_wptr[k]                 <= r_wptr[k] + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + 1'b1;
                end
                r_count[k] <= r_count[k] + CNT_W'(w_push[k]) - CNT_W'(w_pop[k]);
            end
            r_we <= w_any_grant;
            if (w_any_grant) begin
                r_addr   <= w_req_addr[w_grant_idx];
                r_data   <= w_req_data[w_grant_idx];
                r_rr_ptr <= w_grant_idx;
            end
        end
    end

    // Hazard if the register is queued, arriving now, or being written this cycle.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                w_off = PTR_W'(j) - r_rptr[k];
                if (({1'b0, w_off} < r_count[k]) && (r_fifo_addr[k][j] == query_addr_i)) begin
                    w_hit = 1'b1;
                end
            end
            if (w_accept[k] && (src_addr_i[k*RW +: RW] == query_addr_i)) begin
                w_hit = 1'b1;
            end
        end
        if (r_we && (r_addr == query_addr_i)) begin
            w_hit = 1'b1;
        end
    end

    assign query_hit_o = (query_addr_i != '0) && w_hit;
    assign rf_we_o     = r_we;
    assign rf_addr_o   = r_addr;
    assign rf_data_o   = r_data;
endmodule

// File: tb/tb_jedro_1_wb_arbiter.sv
// tb/tb_jedro_1_wb_arbiter.sv - bench for the writeback arbiter: fixed-priority x2 and round-robin x3 instances
module tb_jedro_1_wb_arbiter;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  a_valid, a_rdy;
    logic [9:0]  a_addr;
    logic [63:0] a_data;
    logic        a_flush, a_rstn, a_we, a_qhit;
    logic [4:0]  a_qaddr, a_raddr;
    logic [31:0] a_rdata;

    logic [2:0]  b_valid, b_rdy;
    logic [14:0] b_addr;
    logic [95:0] b_data;
    logic        b_flush, b_rstn, b_we, b_qhit;
    logic [4:0]  b_qaddr, b_raddr;
    logic [31:0] b_rdata;

    jedro_1_wb_arbiter #(.NUM_SRC(2), .FIFO_DEPTH(2), .ARB_MODE(0), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut_a (
        .clk_i(clk), .rstn_i(a_rstn), .flush_i(a_flush),
        .src_valid_i(a_valid), .src_ready_o(a_rdy), .src_addr_i(a_addr), .src_data_i(a_data),
        .rf_we_o(a_we), .rf_addr_o(a_raddr), .rf_data_o(a_rdata),
        .query_addr_i(a_qaddr), .query_hit_o(a_qhit)
    );

    jedro_1_wb_arbiter #(.NUM_SRC(3), .FIFO_DEPTH(2), .ARB_MODE(1), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut_b (
        .clk_i(clk), .rstn_i(b_rstn), .flush_i(b_flush),
        .src_valid_i(b_valid), .src_ready_o(b_rdy), .src_addr_i(b_addr), .src_data_i(b_data),
        .rf_we_o(b_we), .rf_addr_o(b_raddr), .rf_data_o(b_rdata),
        .query_addr_i(b_qaddr), .query_hit_o(b_qhit)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Model: each source is a plain queue; arrivals join the tail, the chosen source loses its head.
    logic [36:0] mq[6][$];
    logic        m_we[2];
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2];
    int          m_last[2];
    bit          m_init[2] = '{1'b0, 1'b0};

    task automatic model_step(input int m, input int ns, input int mode,
                              input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic fl, input logic rn, input logic [4:0] qa,
                              input logic [2:0] rdy, input logic qh,
                              input logic we, input logic [4:0] ra, input logic [31:0] rd);
        logic [2:0]  exp_rdy;
        logic        exp_qh;
        logic [36:0] e;
        int          g;
        if (m_init[m]) begin
            chk($sformatf("m%0d rf_we", m), we, m_we[m]);
            chk($sformatf("m%0d rf_addr", m), ra, m_addr[m]);
            chk($sformatf("m%0d rf_data", m), rd, m_data[m]);
        end
        exp_rdy = '0;
        for (int k = 0; k < ns; k++) exp_rdy[k] = rn && !fl && (mq[m*3+k].size() < 2);
        chk($sformatf("m%0d src_ready", m), rdy, exp_rdy);
        if (m_init[m]) begin
            exp_qh = 1'b0;
            if (qa != 5'd0) begin
                for (int k = 0; k < ns; k++) begin
                    foreach (mq[m*3+k][i]) if (mq[m*3+k][i][36:32] == qa) exp_qh = 1'b1;
                    if (v[k] && exp_rdy[k] && a[k*5 +: 5] == qa) exp_qh = 1'b1;
                end
                if (m_we[m] && m_addr[m] == qa) exp_qh = 1'b1;
            end
            chk($sformatf("m%0d query_hit", m), qh, exp_qh);
        end
        if (!rn || fl) begin
            for (int k = 0; k < 3; k++) mq[m*3+k].delete();
            m_we[m]   = 1'b0;
            m_last[m] = ns - 1;
            if (!rn) begin
                m_addr[m] = '0;
                m_data[m] = '0;
                m_init[m] = 1'b1;
            end
        end else begin
            for (int k = 0; k < ns; k++)
                if (v[k] && exp_rdy[k] && a[k*5 +: 5] != 5'd0)
                    mq[m*3+k].push_back({a[k*5 +: 5], d[k*32 +: 32]});
            g = -1;
            if (mode == 0) begin
                for (int k = 0; k < ns && g < 0; k++) if (mq[m*3+k].size() > 0) g = k;
            end else begin
                for (int i = 1; i <= ns && g < 0; i++) begin
                    int c;
                    c = (m_last[m] + i) % ns;
                    if (mq[m*3+c].size() > 0) g = c;
                end
            end
            if (g >= 0) begin
                e         = mq[m*3+g].pop_front();
                m_we[m]   = 1'b1;
                m_addr[m] = e[36:32];
                m_data[m] = e[31:0];
                m_last[m] = g;
            end else begin
                m_we[m] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step(0, 2, 0, {1'b0, a_valid}, {5'd0, a_addr}, {32'd0, a_data}, a_flush, a_rstn, a_qaddr,
                   {1'b0, a_rdy}, a_qhit, a_we, a_raddr, a_rdata);
        model_step(1, 3, 1, b_valid, b_addr, b_data, b_flush, b_rstn, b_qaddr,
                   b_rdy, b_qhit, b_we, b_raddr, b_rdata);
    end

    logic [36:0] src_q[3][$];
    logic [2:0]  rdy_log[$];
    logic [4:0]  wr_log[$];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Offer each source's queue head until accepted; log ready and written addresses per cycle.
    task automatic run(input int m, input int ncyc);
        int ns;
        ns = (m == 0) ? 2 : 3;
        for (int c = 0; c < ncyc; c++) begin
            logic [2:0]  v, r;
            logic [14:0] ad;
            logic [95:0] dt;
            v = '0; ad = '0; dt = '0;
            for (int k = 0; k < ns; k++) begin
                if (src_q[k].size() > 0) begin
                    v[k]           = 1'b1;
                    ad[k*5 +: 5]   = src_q[k][0][36:32];
                    dt[k*32 +: 32] = src_q[k][0][31:0];
                end
            end
            if (m == 0) begin
                a_valid = v[1:0]; a_addr = ad[9:0]; a_data = dt[63:0];
            end else begin
                b_valid = v; b_addr = ad; b_data = dt;
            end
            #1;
            r = (m == 0) ? {1'b0, a_rdy} : b_rdy;
            rdy_log.push_back(r);
            cyc();
            for (int k = 0; k < ns; k++) if (v[k] && r[k]) void'(src_q[k].pop_front());
            if (m == 0 ? a_we : b_we) wr_log.push_back(m == 0 ? a_raddr : b_raddr);
        end
        a_valid = '0;
        b_valid = '0;
    endtask

    task automatic fill(input int k, input logic [4:0] addrs[$]);
        foreach (addrs[i]) src_q[k].push_back({addrs[i], 27'h5A00000, addrs[i]});
    endtask

    task automatic chk_log(input string nm, input logic [4:0] exp[$]);
        chk({nm, " count"}, wr_log.size(), exp.size());
        foreach (exp[i]) if (i < wr_log.size()) chk($sformatf("%s[%0d]", nm, i), wr_log[i], exp[i]);
    endtask

    task automatic setup_pending();
        a_valid = 2'b11; a_addr = {5'd14, 5'd4}; a_data = {32'hE, 32'h4};
        cyc();
        a_addr = {5'd15, 5'd5}; a_data = {32'hF, 32'h5};
        cyc();
        a_valid = 2'b00;
    endtask

    initial begin
        a_valid = '0; a_addr = '0; a_data = '0; a_flush = 1'b0; a_rstn = 1'b0; a_qaddr = '0;
        b_valid = '0; b_addr = '0; b_data = '0; b_flush = 1'b0; b_rstn = 1'b0; b_qaddr = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst ready_a", a_rdy, 2'b00);
        chk("rst we_a", a_we, 1'b0);
        chk("rst addr_a", a_raddr, 5'd0);
        chk("rst data_a", a_rdata, 32'd0);
        a_rstn = 1'b1; b_rstn = 1'b1;
        #1;
        chk("post-rst ready_a", a_rdy, 2'b11);
        chk("post-rst ready_b", b_rdy, 3'b111);

        cyc();
        a_valid = 2'b01; a_addr = {5'd0, 5'd5}; a_data = {32'd0, 32'h1234_5678};
        cyc();
        a_valid = 2'b00;
        chk("lat we", a_we, 1'b1);
        chk("lat addr", a_raddr, 5'd5);
        chk("lat data", a_rdata, 32'h1234_5678);
        cyc();
        chk("lat we off", a_we, 1'b0);

        fill(0, '{5'd1, 5'd2, 5'd3});
        fill(1, '{5'd11, 5'd12, 5'd13});
        rdy_log.delete(); wr_log.delete();
        run(0, 10);
        chk_log("prio", '{5'd1, 5'd2, 5'd3, 5'd11, 5'd12, 5'd13});
        chk("prio ready1 c1", rdy_log[1][1], 1'b1);
        chk("prio ready1 c2", rdy_log[2][1], 1'b0);
        chk("prio ready1 c4", rdy_log[4][1], 1'b1);

        a_valid = 2'b10; a_addr = 10'd0; a_data = {32'hDEAD, 32'd0}; a_qaddr = 5'd0;
        #1;
        chk("x0 ready1", a_rdy[1], 1'b1);
        chk("x0 query", a_qhit, 1'b0);
        cyc();
        a_valid = 2'b00;
        chk("x0 we", a_we, 1'b0);
        cyc();
        chk("x0 we2", a_we, 1'b0);

        a_valid = 2'b11; a_addr = {5'd7, 5'd3}; a_data = {32'h77, 32'h33};
        cyc();
        a_valid = 2'b00; a_qaddr = 5'd7;
        chk("x7 first write", a_raddr, 5'd3);
        #1;
        chk("x7 query hit", a_qhit, 1'b1);
        a_qaddr = 5'd9;
        #1;
        chk("x9 query miss", a_qhit, 1'b0);
        cyc();
        chk("x7 drained addr", a_raddr, 5'd7);
        chk("x7 drained data", a_rdata, 32'h77);
        a_qaddr = 5'd0;
        cyc();

        fill(0, '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6});
        fill(1, '{5'd8, 5'd9, 5'd10});
        rdy_log.delete(); wr_log.delete();
        run(0, 12);
        chk_log("full", '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10});
        chk("full ready1 c3", rdy_log[3][1], 1'b0);
        chk("full ready1 c6", rdy_log[6][1], 1'b0);
        chk("full ready1 c7", rdy_log[7][1], 1'b1);

        fill(0, '{5'd1, 5'd2, 5'd3, 5'd4});
        fill(1, '{5'd11, 5'd12, 5'd13, 5'd14});
        fill(2, '{5'd21, 5'd22, 5'd23, 5'd24});
        rdy_log.delete(); wr_log.delete();
        run(1, 16);
        chk_log("rr", '{5'd1, 5'd11, 5'd21, 5'd2, 5'd12, 5'd22, 5'd3, 5'd13, 5'd23, 5'd4, 5'd14, 5'd24});

        setup_pending();
        a_flush = 1'b1; a_qaddr = 5'd14;
        chk("flush prev we", a_we, 1'b1);
        #1;
        chk("flush ready", a_rdy, 2'b00);
        chk("flush pending hit", a_qhit, 1'b1);
        cyc();
        a_flush = 1'b0;
        chk("flush we", a_we, 1'b0);
        #1;
        chk("flush emptied", a_qhit, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("flush idle %0d", i), a_we, 1'b0);
        end

        setup_pending();
        a_rstn = 1'b0;
        #1;
        chk("mid-rst ready", a_rdy, 2'b00);
        cyc();
        a_rstn = 1'b1;
        chk("mid-rst we", a_we, 1'b0);
        chk("mid-rst addr", a_raddr, 5'd0);
        chk("mid-rst data", a_rdata, 32'd0);
        #1;
        chk("mid-rst ready after", a_rdy, 2'b11);
        chk("mid-rst emptied", a_qhit, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rst idle %0d", i), a_we, 1'b0);
        end
        a_qaddr = 5'd0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
